// File: rtl/quickq_deq_ctrl.sv
// Purpose : dequeue-side controller for the QuickQ sorted BRAM queue. Reads the
//           head (address 0), presents it on deq_valid/deq_ready, shifts entries
//           1..cnt_q-1 down by one, writes SENTINEL into the freed slot and pulses cnt_dec.
// Latency : request to deq_valid 3 cycles; handshake to cnt_dec 2*(cnt_q-1)+2 cycles.
// Backpr. : deq_data/deq_valid held stable in PRESENT until deq_ready; start held off
//           while enq_busy.
// Ports   : clk, rst_n (async, active low); deq_req/enq_busy/count start the dequeue;
//           deq_valid/deq_ready/deq_data consumer port; busy, cnt_dec, deq_err status;
//           bram_re/bram_rd_addr/bram_rd_data read port (1-cycle latency);
//           bram_we/bram_wr_addr/bram_wr_data write port.
module quickq_deq_ctrl #(
    parameter int              DW       = 32,
    parameter int              DEPTH    = 16,
    parameter int              AW       = $clog2(DEPTH),
    parameter logic [DW-1:0]   SENTINEL = {DW{1'b1}}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          deq_req,
    input  logic          enq_busy,
    input  logic [AW:0]   count,
    output logic          deq_valid,
    input  logic          deq_ready,
    output logic [DW-1:0] deq_data,
    output logic          busy,
    output logic          cnt_dec,
    output logic          deq_err,
    output logic          bram_re,
    output logic [AW-1:0] bram_rd_addr,
    input  logic [DW-1:0] bram_rd_data,
    output logic          bram_we,
    output logic [AW-1:0] bram_wr_addr,
    output logic [DW-1:0] bram_wr_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEAD_RD  = 3'd1,
        HEAD_CAP = 3'd2,
        PRESENT  = 3'd3,
        SHIFT_RD = 3'd4,
        SHIFT_WR = 3'd5,
        CLEAR    = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t      state;
    logic [AW:0] idx;
    logic [AW:0] cnt_q;

    // idx and cnt_q carry one extra bit so a full queue (cnt_q == DEPTH) is representable.
    logic [AW:0] idx_p1;
    logic [AW:0] idx_m1;
    logic [AW:0] cnt_m1;

    assign idx_p1 = idx + (AW+1)'(1);
    assign idx_m1 = idx - (AW+1)'(1);
    assign cnt_m1 = cnt_q - (AW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            deq_valid    <= 1'b0;
            deq_data     <= '0;
            idx          <= '0;
            cnt_q        <= '0;
            bram_rd_addr <= '0;
            bram_wr_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (deq_req && !enq_busy && (count != '0)) begin
                        cnt_q        <= count;
                        bram_rd_addr <= '0;
                        state        <= HEAD_RD;
                    end
                end
                HEAD_RD: begin
                    state <= HEAD_CAP;
                end
                HEAD_CAP: begin
                    deq_data  <= bram_rd_data;
                    deq_valid <= 1'b1;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (deq_ready) begin
                        deq_valid <= 1'b0;
                        idx       <= (AW+1)'(1);
                        if (cnt_q == (AW+1)'(1)) begin
                            bram_wr_addr <= cnt_m1[AW-1:0];
                            state        <= CLEAR;
                        end else begin
                            bram_rd_addr <= AW'(1);
                            state        <= SHIFT_RD;
                        end
                    end
                end
                SHIFT_RD: begin
                    // Target address for the write that follows the read.
                    bram_wr_addr <= idx_m1[AW-1:0];
                    state        <= SHIFT_WR;
                end
                SHIFT_WR: begin
                    idx <= idx_p1;
                    if (idx_p1 == cnt_q) begin
                        bram_wr_addr <= cnt_m1[AW-1:0];
                        state        <= CLEAR;
                    end else begin
                        // idx_p1 < cnt_q <= DEPTH here, so the slice cannot wrap.
                        bram_rd_addr <= idx_p1[AW-1:0];
                        state        <= SHIFT_RD;
                    end
                end
                CLEAR: begin
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state; reads and writes sit in disjoint states,
    // so the BRAM never sees both in one cycle.
    assign bram_re = (state == HEAD_RD) || (state == SHIFT_RD);
    assign bram_we = (state == SHIFT_WR) || (state == CLEAR);
    assign cnt_dec = (state == DONE);
    assign busy    = (state != IDLE);
    assign deq_err = (state == IDLE) && deq_req && (count == '0);

    // Write data selects between the BRAM's own output register (shift) and the
    // empty-slot marker; neither path adds a cycle, and it is zero when idle.
    always_comb begin
        bram_wr_data = '0;
        case (state)
            SHIFT_WR: bram_wr_data = bram_rd_data;
            CLEAR:    bram_wr_data = SENTINEL;
            default:  bram_wr_data = '0;
        endcase
    end

endmodule

// File: tb/tb_quickq_deq_ctrl.sv
module tb_quickq_deq_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [DW-1:0] S = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          deq_req;
    logic          enq_busy;
    logic [AW:0]   count;
    logic          deq_valid;
    logic          deq_ready;
    logic [DW-1:0] deq_data;
    logic          busy;
    logic          cnt_dec;
    logic          deq_err;
    logic          bram_re;
    logic [AW-1:0] bram_rd_addr;
    logic [DW-1:0] bram_rd_data = '0;
    logic          bram_we;
    logic [AW-1:0] bram_wr_addr;
    logic [DW-1:0] bram_wr_data;

    always #5 clk = ~clk;

    quickq_deq_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .deq_req(deq_req), .enq_busy(enq_busy),
        .count(count), .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_data(deq_data), .busy(busy), .cnt_dec(cnt_dec), .deq_err(deq_err),
        .bram_re(bram_re), .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .bram_we(bram_we), .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data)
    );

    // BRAM model plus event monitor
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] load_img [DEPTH];
    logic          load_en = 1'b0;
    int cyc = 0, re_cnt = 0, we_cnt = 0, dec_cnt = 0, err_cnt = 0, busy_cnt = 0;
    int conflict_cnt = 0, hs_cyc = 0, dec_cyc = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= load_img[i];
        end else if (bram_we) begin
            mem[bram_wr_addr] <= bram_wr_data;
        end
        if (bram_re) bram_rd_data <= mem[bram_rd_addr];
        if (bram_re) re_cnt <= re_cnt + 1;
        if (bram_we) begin
            we_cnt       <= we_cnt + 1;
            last_wr_addr <= bram_wr_addr;
            last_wr_data <= bram_wr_data;
        end
        if (bram_re && bram_we) conflict_cnt <= conflict_cnt + 1;
        if (cnt_dec) dec_cnt <= dec_cnt + 1;
        if (deq_err) err_cnt <= err_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (deq_valid && deq_ready) hs_cyc <= cyc;
        if (cnt_dec) dec_cyc <= cyc;
    end

    int tests = 0;
    int fails = 0;

    task automatic do_load();
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [77:0] outs;
        rst_n = 1'b0; deq_req = 1'b0; enq_busy = 1'b0; count = '0; deq_ready = 1'b0;
        @(negedge clk);
        outs = {deq_valid, deq_data, busy, cnt_dec, deq_err, bram_re, bram_rd_addr,
                bram_we, bram_wr_addr, bram_wr_data};
        tests++;
        if (outs !== 78'd0) begin
            fails++; $display("FAIL reset_outputs got=%h want=0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int re0, we0, dec0, cf0;
        bit ok;
        for (int i = 0; i < DEPTH; i++) load_img[i] = S;
        load_img[0] = 3; load_img[1] = 7; load_img[2] = 9;
        do_load();
        count = 5'd3; deq_ready = 1'b1;
        re0 = re_cnt; we0 = we_cnt; dec0 = dec_cnt; cf0 = conflict_cnt;
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        tests++;
        if (!(bram_re === 1'b1 && bram_rd_addr === 4'd0)) begin
            fails++; $display("FAIL basic_head_rd got re=%b addr=%0d want re=1 addr=0", bram_re, bram_rd_addr);
        end
        @(negedge clk);
        tests++;
        if (deq_valid !== 1'b0) begin
            fails++; $display("FAIL basic_early_valid got=%b want=0", deq_valid);
        end
        @(negedge clk);
        tests++;
        if (!(deq_valid === 1'b1 && deq_data === 32'd3)) begin
            fails++; $display("FAIL basic_head got valid=%b data=%0d want valid=1 data=3", deq_valid, deq_data);
        end
        wait_idle(ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL basic_timeout got busy=%b want 0", busy);
        end
        tests++;
        if (!(mem[0] === 32'd7 && mem[1] === 32'd9 && mem[2] === S)) begin
            fails++; $display("FAIL basic_bram got=%0d,%0d,%h want=7,9,ffffffff", mem[0], mem[1], mem[2]);
        end
        tests++;
        if (!(dec_cnt - dec0 == 1 && re_cnt - re0 == 3 && we_cnt - we0 == 3 && conflict_cnt == cf0)) begin
            fails++; $display("FAIL basic_counts got dec=%0d re=%0d we=%0d conf=%0d want 1,3,3,0",
                              dec_cnt - dec0, re_cnt - re0, we_cnt - we0, conflict_cnt - cf0);
        end
    endtask

    task automatic test_single();
        int re0, we0, dec0;
        bit ok;
        for (int i = 0; i < DEPTH; i++) load_img[i] = S;
        load_img[0] = 5; load_img[1] = 77;
        do_load();
        count = 5'd1; deq_ready = 1'b1;
        re0 = re_cnt; we0 = we_cnt; dec0 = dec_cnt;
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (!(deq_valid === 1'b1 && deq_data === 32'd5)) begin
            fails++; $display("FAIL single_head got valid=%b data=%0d want valid=1 data=5", deq_valid, deq_data);
        end
        wait_idle(ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL single_timeout got busy=%b want 0", busy);
        end
        tests++;
        if (!(we_cnt - we0 == 1 && last_wr_addr === 4'd0 && last_wr_data === S && re_cnt - re0 == 1)) begin
            fails++; $display("FAIL single_writes got we=%0d addr=%0d data=%h re=%0d want 1,0,ffffffff,1",
                              we_cnt - we0, last_wr_addr, last_wr_data, re_cnt - re0);
        end
        tests++;
        if (!(mem[0] === S && mem[1] === 32'd77 && dec_cnt - dec0 == 1)) begin
            fails++; $display("FAIL single_bram got m0=%h m1=%0d dec=%0d want ffffffff,77,1", mem[0], mem[1], dec_cnt - dec0);
        end
    endtask

    task automatic test_empty();
        int re0, we0, err0, b0;
        count = '0;
        re0 = re_cnt; we0 = we_cnt; err0 = err_cnt; b0 = busy_cnt;
        deq_req = 1'b1;
        #1;
        tests++;
        if (!(deq_err === 1'b1 && busy === 1'b0)) begin
            fails++; $display("FAIL empty_err got err=%b busy=%b want 1,0", deq_err, busy);
        end
        @(negedge clk);
        @(negedge clk);
        deq_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!(err_cnt - err0 == 2 && re_cnt == re0 && we_cnt == we0 && busy_cnt == b0)) begin
            fails++; $display("FAIL empty_counts got err=%0d re=%0d we=%0d busy=%0d want 2,0,0,0",
                              err_cnt - err0, re_cnt - re0, we_cnt - we0, busy_cnt - b0);
        end
    endtask

    task automatic test_full_backpressure();
        int bad, dec0;
        bit ok;
        for (int i = 0; i < DEPTH; i++) load_img[i] = i;
        do_load();
        count = 5'd16; deq_ready = 1'b0;
        dec0 = dec_cnt;
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(deq_valid === 1'b1 && deq_data === 32'd0)) bad++;
            @(negedge clk);
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL full_stable got %0d unstable cycles want 0", bad);
        end
        deq_ready = 1'b1;
        wait_idle(ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL full_timeout got busy=%b want 0", busy);
        end
        tests++;
        if (!(dec_cyc - hs_cyc == 32 && dec_cnt - dec0 == 1)) begin
            fails++; $display("FAIL full_latency got=%0d pulses=%0d want 32,1", dec_cyc - hs_cyc, dec_cnt - dec0);
        end
        bad = 0;
        for (int i = 0; i < DEPTH - 1; i++) if (mem[i] !== DW'(i + 1)) bad++;
        if (mem[DEPTH-1] !== S) bad++;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL full_bram got %0d wrong entries want 0 (m0=%0d m15=%h)", bad, mem[0], mem[15]);
        end
    endtask

    task automatic test_enq_busy();
        int bad, re0;
        bit ok;
        for (int i = 0; i < DEPTH; i++) load_img[i] = S;
        load_img[0] = 4; load_img[1] = 8;
        do_load();
        count = 5'd2; deq_ready = 1'b1; enq_busy = 1'b1;
        re0 = re_cnt;
        deq_req = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || bram_re !== 1'b0) bad++;
        end
        tests++;
        if (!(bad == 0 && re_cnt == re0)) begin
            fails++; $display("FAIL enqbusy_hold got bad=%0d re=%0d want 0,0", bad, re_cnt - re0);
        end
        enq_busy = 1'b0;
        @(negedge clk);
        deq_req = 1'b0;
        tests++;
        if (bram_re !== 1'b1) begin
            fails++; $display("FAIL enqbusy_start got re=%b want 1", bram_re);
        end
        wait_idle(ok);
        tests++;
        if (!(ok && mem[0] === 32'd8 && mem[1] === S)) begin
            fails++; $display("FAIL enqbusy_bram got ok=%b m0=%0d m1=%h want 1,8,ffffffff", ok, mem[0], mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        int n, nval, dec_at, rd_at;
        logic [DW-1:0] v0, v1;
        for (int i = 0; i < DEPTH; i++) load_img[i] = S;
        load_img[0] = 1; load_img[1] = 2;
        do_load();
        count = 5'd2; deq_ready = 1'b1;
        v0 = '0; v1 = '0; nval = 0; dec_at = -1; rd_at = -1;
        deq_req = 1'b1;
        n = 0;
        while (n < 60 && count != '0) begin
            @(negedge clk);
            n++;
            if (deq_valid) begin
                if (nval == 0) v0 = deq_data; else v1 = deq_data;
                nval++;
            end
            if (bram_re && bram_rd_addr == '0 && dec_at >= 0 && rd_at < 0) rd_at = n;
            if (cnt_dec) begin
                if (dec_at < 0) dec_at = n;
                count = count - 5'd1;
                if (count == '0) deq_req = 1'b0;
            end
        end
        deq_req = 1'b0;
        @(negedge clk);
        tests++;
        if (!(nval == 2 && v0 === 32'd1 && v1 === 32'd2)) begin
            fails++; $display("FAIL b2b_data got n=%0d v0=%0d v1=%0d want 2,1,2", nval, v0, v1);
        end
        tests++;
        if (rd_at - dec_at != 2) begin
            fails++; $display("FAIL b2b_restart got gap=%0d want 2", rd_at - dec_at);
        end
        tests++;
        if (!(mem[0] === S && mem[1] === S && busy === 1'b0)) begin
            fails++; $display("FAIL b2b_bram got m0=%h m1=%h busy=%b want ffffffff,ffffffff,0", mem[0], mem[1], busy);
        end
    endtask

    task automatic test_reset_mid();
        int n, we0;
        logic [77:0] outs;
        bit seen;
        for (int i = 0; i < DEPTH; i++) load_img[i] = S;
        load_img[0] = 10; load_img[1] = 20; load_img[2] = 30; load_img[3] = 40;
        do_load();
        count = 5'd4; deq_ready = 1'b1;
        deq_req = 1'b1;
        @(negedge clk);
        deq_req = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (bram_we) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++; $display("FAIL rstmid_reach got no shift write want one");
        end
        rst_n = 1'b0;
        #1;
        outs = {deq_valid, deq_data, busy, cnt_dec, deq_err, bram_re, bram_rd_addr,
                bram_we, bram_wr_addr, bram_wr_data};
        tests++;
        if (outs !== 78'd0) begin
            fails++; $display("FAIL rstmid_outputs got=%h want=0", outs);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we0 = we_cnt;
        repeat (20) @(negedge clk);
        tests++;
        if (!(we_cnt == we0 && busy === 1'b0)) begin
            fails++; $display("FAIL rstmid_quiet got writes=%0d busy=%b want 0,0", we_cnt - we0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_empty();
        test_full_backpressure();
        test_enq_busy();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
